// File: rtl/pipe_skid_latch.sv
// pipe_skid_latch: valid/ready pipeline latch with a one-entry skid buffer, flush bubble injection
// and saturating stall/drop counters.
module pipe_skid_latch #(
  parameter int WIDTH = 64,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int CNT_W = 16
)(
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] drop_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] main_q, skid_q, main_nx, skid_nx;
  logic accept, take;
  logic [1:0] held;
  logic [CNT_W:0] drop_sum;
  assign in_ready  = state != TWO;
  assign out_valid = state != EMPTY;
  assign out_data  = out_valid ? main_q : NOP_VALUE;
  assign accept    = in_valid & in_ready;
  assign take      = out_valid & out_ready;
  assign held      = state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
  // an entry taken downstream during a flush is delivered, not dropped
  assign drop_sum  = {1'b0, drop_cnt} + (CNT_W+1)'(held) + (CNT_W+1)'(accept) - (CNT_W+1)'(take);
  always_comb begin
    state_nx = state;
    main_nx  = main_q;
    skid_nx  = skid_q;
    if (flush) state_nx = EMPTY;
    else case (state)
      EMPTY: if (accept) begin
        state_nx = ONE;
        main_nx  = in_data;
      end
      ONE: begin
        if (accept & take) main_nx = in_data;
        else if (accept) begin
          state_nx = TWO;
          skid_nx  = in_data;
        end else if (take) state_nx = EMPTY;
      end
      default: if (take) begin
        state_nx = ONE;
        main_nx  = skid_q;
      end
    endcase
  end
  always_ff @(posedge CLK) begin
    main_q <= main_nx;
    skid_q <= skid_nx;
    if (RST) begin
      state     <= EMPTY;
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (out_valid & ~out_ready & (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_pipe_skid_latch.sv
// tb_pipe_skid_latch: table-driven vectors with a FIFO scoreboard on the main instance,
// plus a narrow-counter instance for saturation sequences.
module tb_pipe_skid_latch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        m_rst, m_flush, m_iv, m_ir, m_ov, m_ordy;
  logic [15:0] m_id, m_od, m_sc, m_dc;
  logic        s_rst, s_flush, s_iv, s_ir, s_ov, s_ordy;
  logic [15:0] s_id, s_od;
  logic [1:0]  s_sc, s_dc;

  pipe_skid_latch #(.WIDTH(16), .NOP_VALUE(16'hDEAD), .CNT_W(16)) dut (
    .CLK(clk), .RST(m_rst), .flush(m_flush), .in_valid(m_iv), .in_ready(m_ir), .in_data(m_id),
    .out_valid(m_ov), .out_ready(m_ordy), .out_data(m_od), .stall_cnt(m_sc), .drop_cnt(m_dc));

  pipe_skid_latch #(.WIDTH(16), .NOP_VALUE(16'hDEAD), .CNT_W(2)) dut_sat (
    .CLK(clk), .RST(s_rst), .flush(s_flush), .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
    .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od), .stall_cnt(s_sc), .drop_cnt(s_dc));

  typedef struct {
    logic r, f, v; logic [15:0] d; logic o;
    logic ir, ov; logic [15:0] od, sc, dc;
  } vec_t;

  vec_t tbl[$];
  logic [15:0] sb[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic s_step(input logic r, f, v, input logic [15:0] d, input logic o);
    @(negedge clk);
    s_rst = r; s_flush = f; s_iv = v; s_id = d; s_ordy = o;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic pir, pov;
    {m_rst, m_flush, m_iv, m_ordy, m_id} = '0;
    {s_rst, s_flush, s_iv, s_ordy, s_id} = '0;
    //           r  f  v  d       o    ir ov od        sc  dc
    tbl.push_back('{1, 0, 1, 16'h99, 0,  1, 0, 16'hDEAD, 0, 0});
    tbl.push_back('{0, 0, 1, 16'h1,  1,  1, 1, 16'h1,    0, 0});
    tbl.push_back('{0, 0, 1, 16'h2,  1,  1, 1, 16'h2,    0, 0});
    tbl.push_back('{0, 0, 1, 16'h3,  1,  1, 1, 16'h3,    0, 0});
    tbl.push_back('{0, 0, 1, 16'h4,  1,  1, 1, 16'h4,    0, 0});
    tbl.push_back('{0, 0, 0, 16'h0,  1,  1, 0, 16'hDEAD, 0, 0});
    tbl.push_back('{0, 0, 1, 16'hA,  1,  1, 1, 16'hA,    0, 0});
    tbl.push_back('{0, 0, 1, 16'hB,  0,  0, 1, 16'hA,    1, 0});
    tbl.push_back('{0, 0, 1, 16'hC,  0,  0, 1, 16'hA,    2, 0});
    tbl.push_back('{0, 0, 1, 16'hC,  0,  0, 1, 16'hA,    3, 0});
    tbl.push_back('{0, 0, 1, 16'hC,  1,  1, 1, 16'hB,    3, 0});
    tbl.push_back('{0, 0, 1, 16'hC,  1,  1, 1, 16'hC,    3, 0});
    tbl.push_back('{0, 0, 0, 16'h0,  1,  1, 0, 16'hDEAD, 3, 0});
    tbl.push_back('{0, 0, 1, 16'h1,  0,  1, 1, 16'h1,    3, 0});
    tbl.push_back('{0, 0, 1, 16'h2,  0,  0, 1, 16'h1,    4, 0});
    tbl.push_back('{0, 1, 1, 16'h3,  0,  1, 0, 16'hDEAD, 5, 2});
    tbl.push_back('{0, 0, 1, 16'h4,  0,  1, 1, 16'h4,    5, 2});
    tbl.push_back('{0, 1, 1, 16'h5,  0,  1, 0, 16'hDEAD, 6, 4});
    tbl.push_back('{0, 0, 1, 16'h6,  1,  1, 1, 16'h6,    6, 4});
    tbl.push_back('{0, 1, 1, 16'h7,  1,  1, 0, 16'hDEAD, 6, 5});
    tbl.push_back('{0, 0, 1, 16'h8,  0,  1, 1, 16'h8,    6, 5});
    tbl.push_back('{0, 0, 1, 16'h9,  0,  0, 1, 16'h8,    7, 5});
    tbl.push_back('{1, 0, 1, 16'h10, 0,  1, 0, 16'hDEAD, 0, 0});
    tbl.push_back('{0, 0, 0, 16'h0,  1,  1, 0, 16'hDEAD, 0, 0});
    pir = 1'b1;
    pov = 1'b0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      m_rst = tbl[i].r; m_flush = tbl[i].f; m_iv = tbl[i].v; m_id = tbl[i].d; m_ordy = tbl[i].o;
      #1;
      if (tbl[i].r) sb.delete();
      else begin
        if (pov & tbl[i].o) begin
          if (sb.size() == 0) chk($sformatf("row%0d sb_underflow", i), 32'd0, 32'd1);
          else chk($sformatf("row%0d sb_take", i), 32'(m_od), 32'(sb.pop_front()));
        end
        if (tbl[i].f) sb.delete();
        else if (tbl[i].v & pir) sb.push_back(tbl[i].d);
      end
      @(posedge clk);
      #1;
      chk($sformatf("row%0d in_ready", i), 32'(m_ir), 32'(tbl[i].ir));
      chk($sformatf("row%0d out_valid", i), 32'(m_ov), 32'(tbl[i].ov));
      chk($sformatf("row%0d out_data", i), 32'(m_od), 32'(tbl[i].od));
      chk($sformatf("row%0d stall_cnt", i), 32'(m_sc), 32'(tbl[i].sc));
      chk($sformatf("row%0d drop_cnt", i), 32'(m_dc), 32'(tbl[i].dc));
      pir = tbl[i].ir;
      pov = tbl[i].ov;
    end
    chk("sb_drained", 32'(sb.size()), 32'd0);

    s_step(1, 0, 0, 16'h0, 0);
    chk("sat reset stall", 32'(s_sc), 32'd0);
    chk("sat reset drop", 32'(s_dc), 32'd0);
    s_step(0, 0, 1, 16'h11, 1);
    chk("sat load valid", 32'(s_ov), 32'd1);
    for (int k = 1; k <= 6; k++) begin
      s_step(0, 0, 0, 16'h0, 0);
      chk($sformatf("sat stall k%0d", k), 32'(s_sc), (k > 3) ? 32'd3 : 32'(k));
    end
    s_step(0, 0, 1, 16'h22, 0);
    chk("sat two in_ready", 32'(s_ir), 32'd0);
    s_step(0, 1, 0, 16'h0, 0);
    chk("sat flush1 drop", 32'(s_dc), 32'd2);
    chk("sat flush1 valid", 32'(s_ov), 32'd0);
    chk("sat flush1 data", 32'(s_od), 32'hDEAD);
    s_step(0, 0, 1, 16'h33, 1);
    s_step(0, 0, 1, 16'h44, 0);
    chk("sat two data", 32'(s_od), 32'h33);
    s_step(0, 1, 0, 16'h0, 0);
    chk("sat flush2 drop", 32'(s_dc), 32'd3);
    s_step(0, 0, 1, 16'h55, 0);
    s_step(0, 1, 1, 16'h66, 0);
    chk("sat flush3 drop", 32'(s_dc), 32'd3);
    chk("sat stall hold", 32'(s_sc), 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
